// File: rtl/multicycle_ctrl_pkg.sv
// Shared control definitions: FSM state encoding, RV32 subset opcodes and PC source codes.
// Also used by the immediate decoder and datapath.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_ADUQ  = 7'b0001011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;  // PC + 4
    localparam logic [1:0] PC_SRC_REL = 2'd1;  // PC + imm
    localparam logic [1:0] PC_SRC_REG = 2'd2;  // rs1 + imm

    // Wide enough for any timeout limit up to 255 cycles.
    localparam int TIMER_W = 8;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_ADUQ, OP_ADDI, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic op_uses_imm(input logic [6:0] op);
        case (op)
            OP_ADDI, OP_LUI, OP_JALR, OP_LW, OP_SW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the controller and the memory system.
interface multicycle_ctrl_if;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic        dmem_ready;
    logic        mem_req;
    logic        mem_we;

    modport master (
        output imem_req, mem_req, mem_we,
        input  imem_rdata, imem_valid, dmem_ready
    );

    modport slave (
        input  imem_req, mem_req, mem_we,
        output imem_rdata, imem_valid, dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the last one before a timeout.
module ctrl_wait_timer
    import ctrl_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: holds the IR, drives datapath strobes,
// handshakes with instruction/data memory and counts retired instructions.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  mem_if,
    input  logic               alu_zero_i,
    output logic [31:0]        ir_o,
    output logic               imm_control_o,
    output logic               alu_src_imm_o,
    output logic               reg_write_o,
    output logic               pc_we_o,
    output logic [1:0]         pc_src_o,
    output logic               illegal_o,
    output logic               bus_err_o,
    output logic [CNT_W-1:0]   retired_o
);

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               started_q;

    logic [6:0]         opcode;
    logic               is_sw;
    logic               timer_inc;
    logic               timer_clr;
    logic               timer_expire;
    logic               imem_req;
    logic               mem_req;
    logic               mem_we;

    assign opcode = ir_q[6:0];
    assign is_sw  = (opcode == OP_SW);

    ctrl_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .inc_i    (timer_inc),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        imem_req      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        imm_control_o = 1'b0;
        alu_src_imm_o = 1'b0;
        reg_write_o   = 1'b0;
        pc_we_o       = 1'b0;
        pc_src_o      = PC_SRC_SEQ;
        illegal_o     = 1'b0;
        bus_err_o     = 1'b0;
        timer_inc     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Held idle until the first edge after reset release.
                if (started_q) begin
                    imem_req = 1'b1;
                    if (mem_if.imem_valid) begin
                        ir_d    = mem_if.imem_rdata;
                        state_d = ST_DECODE;
                    end else begin
                        timer_inc = 1'b1;
                        bus_err_o = timer_expire;
                    end
                end
            end
            ST_DECODE: begin
                imm_control_o = 1'b1;
                if (!op_supported(opcode)) begin
                    illegal_o = 1'b1;
                    pc_we_o   = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                imm_control_o = 1'b1;
                alu_src_imm_o = op_uses_imm(opcode);
                state_d       = ST_FETCH;
                case (opcode)
                    OP_R, OP_ADUQ, OP_ADDI, OP_LUI, OP_AUIPC: begin
                        reg_write_o = 1'b1;
                        pc_we_o     = 1'b1;
                    end
                    OP_BEQ: begin
                        pc_we_o  = 1'b1;
                        pc_src_o = alu_zero_i ? PC_SRC_REL : PC_SRC_SEQ;
                    end
                    OP_JAL: begin
                        reg_write_o = 1'b1;
                        pc_we_o     = 1'b1;
                        pc_src_o    = PC_SRC_REL;
                    end
                    OP_JALR: begin
                        reg_write_o = 1'b1;
                        pc_we_o     = 1'b1;
                        pc_src_o    = PC_SRC_REG;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                // A completion landing on the timeout cycle still counts as success.
                if (mem_if.dmem_ready) begin
                    if (is_sw) begin
                        pc_we_o = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expire) begin
                        bus_err_o = 1'b1;
                        pc_we_o   = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_write_o = 1'b1;
                pc_we_o     = 1'b1;
                state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        timer_clr = (state_d != state_q) || bus_err_o;
        retired_d = retired_q;
        if (pc_we_o && !illegal_o && !bus_err_o) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            started_q <= 1'b1;
        end
    end

    assign mem_if.imem_req = imem_req;
    assign mem_if.mem_req  = mem_req;
    assign mem_if.mem_we   = mem_we;
    assign ir_o            = ir_q;
    assign retired_o       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instruction transactions with a
// reactive memory model and scoreboard, plus hand sequences for reset and fetch timeout.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_zero;
    logic [31:0] ir;
    logic        imm_control, alu_src_imm, reg_write, pc_we, illegal, bus_err;
    logic [1:0]  pc_src;
    logic [31:0] retired;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_if        (bus),
        .alu_zero_i    (alu_zero),
        .ir_o          (ir),
        .imm_control_o (imm_control),
        .alu_src_imm_o (alu_src_imm),
        .reg_write_o   (reg_write),
        .pc_we_o       (pc_we),
        .pc_src_o      (pc_src),
        .illegal_o     (illegal),
        .bus_err_o     (bus_err),
        .retired_o     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        int          fdelay;   // imem_req cycles before imem_valid
        int          dwait;    // mem_req cycles before dmem_ready
        int          cyc;      // cycles from first FETCH to the pc_we exit
        logic        rw;
        logic [1:0]  src;
        logic        asi;
        logic        mwe;
        logic        ill;
        int          berr;
        int          mreq;
        logic        ret;
    } vec_t;

    vec_t        vecs [19];
    vec_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          model_ret = 0;
    logic [31:0] model_ir  = 32'h0;

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic zero,
                                input int fdelay, input int dwait, input int cyc, input logic rw,
                                input logic [1:0] src, input logic asi, input logic mwe,
                                input logic ill, input int berr, input int mreq, input logic ret);
        vec_t v;
        v.name = name;  v.instr = instr; v.zero = zero; v.fdelay = fdelay; v.dwait = dwait;
        v.cyc = cyc;    v.rw = rw;       v.src = src;   v.asi = asi;       v.mwe = mwe;
        v.ill = ill;    v.berr = berr;   v.mreq = mreq; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_instr(input vec_t v);
        int          cyc, fcnt, mcnt, immc, berr, mreqc;
        logic        fetched, done, rw, rw_stray, asi, mwe, ill;
        logic [1:0]  src;
        vec_t        e;
        cyc = 0; fcnt = 0; mcnt = 0; immc = 0; berr = 0; mreqc = 0;
        fetched = 0; done = 0; rw = 0; rw_stray = 0; asi = 0; mwe = 0; ill = 0; src = 2'd0;
        sb.push_back(v);
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            bus.imem_valid = 1'b0;
            bus.imem_rdata = $urandom;
            bus.dmem_ready = 1'b0;
            alu_zero       = v.zero;
            if (bus.imem_req && !fetched) begin
                if (fcnt == v.fdelay) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = v.instr;
                    fetched        = 1'b1;
                end
                fcnt++;
            end
            if (bus.mem_req) begin
                mreqc++;
                if (mcnt == v.dwait) bus.dmem_ready = 1'b1;
                mcnt++;
            end
            #1;
            if (imm_control) immc++;
            if (bus_err)     berr++;
            if (alu_src_imm) asi = 1'b1;
            if (bus.mem_we)  mwe = 1'b1;
            if (illegal)     ill = 1'b1;
            if (reg_write) begin
                if (pc_we) rw = 1'b1;
                else       rw_stray = 1'b1;
            end
            if (pc_we) begin
                done = 1'b1;
                src  = pc_src;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s.exit: got no pc_we within %0d cycles want pc_we", e.name, cyc);
        end
        chk({e.name, ".cycles"},   cyc,      e.cyc);
        chk({e.name, ".reg_write"}, rw,      e.rw);
        chk({e.name, ".rw_stray"}, rw_stray, 1'b0);
        chk({e.name, ".pc_src"},   src,      e.src);
        chk({e.name, ".alu_src"},  asi,      e.asi);
        chk({e.name, ".mem_we"},   mwe,      e.mwe);
        chk({e.name, ".illegal"},  ill,      e.ill);
        chk({e.name, ".bus_err"},  berr,     e.berr);
        chk({e.name, ".mem_req"},  mreqc,    e.mreq);
        chk({e.name, ".imm_ctrl"}, immc,     e.ill ? 1 : 2);
        @(posedge clk);
        #1;
        if (e.ret) model_ret++;
        model_ir = e.instr;
        chk({e.name, ".retired"}, retired, model_ret);
        chk({e.name, ".ir"},      ir,      model_ir);
        $display("txn %s instr=0x%08h cycles=%0d pc_src=%0d bus_err=%0d retired=%0d",
                 e.name, e.instr, cyc, src, berr, retired);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pulses, badpos, notfetch;
        logic [8:0]  strobes;

        vecs[0]  = mk("addi",      32'h00500093, 0,  0,  0,  3, 1, 2'd0, 1, 0, 0, 0,  0, 1);
        vecs[1]  = mk("lw_w2",     32'h00002083, 0,  0,  2,  7, 1, 2'd0, 1, 0, 0, 0,  3, 1);
        vecs[2]  = mk("beq_z1",    32'h00000463, 1,  0,  0,  3, 0, 2'd1, 0, 0, 0, 0,  0, 1);
        vecs[3]  = mk("beq_z0",    32'h00000463, 0,  0,  0,  3, 0, 2'd0, 0, 0, 0, 0,  0, 1);
        vecs[4]  = mk("illegal7f", 32'h0000007F, 0,  0,  0,  2, 0, 2'd0, 0, 0, 1, 0,  0, 0);
        vecs[5]  = mk("sw",        32'h00112023, 0,  0,  0,  4, 0, 2'd0, 1, 1, 0, 0,  1, 1);
        vecs[6]  = mk("jal",       32'h0000006F, 0,  0,  0,  3, 1, 2'd1, 0, 0, 0, 0,  0, 1);
        vecs[7]  = mk("jalr",      32'h00008067, 0,  0,  0,  3, 1, 2'd2, 1, 0, 0, 0,  0, 1);
        vecs[8]  = mk("add",       32'h002081B3, 0,  0,  0,  3, 1, 2'd0, 0, 0, 0, 0,  0, 1);
        vecs[9]  = mk("aduq",      32'h0000000B, 0,  0,  0,  3, 1, 2'd0, 0, 0, 0, 0,  0, 1);
        vecs[10] = mk("lui",       32'h000010B7, 0,  0,  0,  3, 1, 2'd0, 1, 0, 0, 0,  0, 1);
        vecs[11] = mk("auipc",     32'h00001097, 0,  0,  0,  3, 1, 2'd0, 0, 0, 0, 0,  0, 1);
        vecs[12] = mk("sw_w3",     32'h00112023, 0,  0,  3,  7, 0, 2'd0, 1, 1, 0, 0,  4, 1);
        vecs[13] = mk("fetch_w15", 32'h00500093, 0, 15,  0, 18, 1, 2'd0, 1, 0, 0, 0,  0, 1);
        vecs[14] = mk("fetch_w20", 32'h00500093, 0, 20,  0, 23, 1, 2'd0, 1, 0, 0, 1,  0, 1);
        vecs[15] = mk("lw_tmo",    32'h00002083, 0,  0, 16, 19, 0, 2'd0, 1, 0, 0, 1, 16, 0);
        vecs[16] = mk("lw_w15",    32'h00002083, 0,  0, 15, 20, 1, 2'd0, 1, 0, 0, 0, 16, 1);
        vecs[17] = mk("sw_tmo",    32'h00112023, 0,  0, 16, 19, 0, 2'd0, 1, 1, 0, 1, 16, 0);
        vecs[18] = mk("illegal77", 32'h12345677, 0,  0,  0,  2, 0, 2'd0, 0, 0, 1, 0,  0, 0);

        rst_n          = 1'b0;
        alu_zero       = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_ready = 1'b0;

        // Reset state, then release between edges.
        @(negedge clk);
        @(negedge clk);
        #1;
        strobes = {bus.imem_req, bus.mem_req, bus.mem_we, imm_control, alu_src_imm,
                   reg_write, pc_we, illegal, bus_err};
        chk("reset.strobes", strobes, 9'h0);
        chk("reset.pc_src",  pc_src, 2'd0);
        chk("reset.retired", retired, 32'h0);
        chk("reset.ir",      ir, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("release.imem_req", bus.imem_req, 1'b0);

        for (int i = 0; i < 19; i++) begin
            run_instr(vecs[i]);
        end

        // Instruction memory never answers: retry with bus_err every 16 cycles.
        pulses = 0; badpos = 0; notfetch = 0;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            bus.imem_valid = 1'b0;
            bus.imem_rdata = $urandom;
            bus.dmem_ready = 1'b0;
            #1;
            if (bus_err) begin
                pulses++;
                if ((c % 16) != 0) badpos++;
            end
            if (!bus.imem_req || pc_we || reg_write) notfetch++;
        end
        chk("fetch_tmo.pulses",  pulses, 3);
        chk("fetch_tmo.pos",     badpos, 0);
        chk("fetch_tmo.hold",    notfetch, 0);
        @(posedge clk);
        #1;
        chk("fetch_tmo.retired", retired, model_ret);
        chk("fetch_tmo.ir",      ir, model_ir);

        // Reset asserted while a LW is stalled in MEM.
        @(negedge clk);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h00002083;
        bus.dmem_ready = 1'b0;
        #1;
        chk("rst_mem.fetch", bus.imem_req, 1'b1);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem.in_mem", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        strobes = {bus.imem_req, bus.mem_req, bus.mem_we, imm_control, alu_src_imm,
                   reg_write, pc_we, illegal, bus_err};
        chk("rst_mem.strobes", strobes, 9'h0);
        chk("rst_mem.retired", retired, 32'h0);
        chk("rst_mem.ir",      ir, 32'h0);
        model_ret = 0;
        @(negedge clk);
        #1;
        chk("rst_mem.held", bus.imem_req, 1'b0);
        rst_n = 1'b1;

        run_instr(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
